// File: rtl/adder_slice_pkg.sv
// Shared types and helpers for the digit-serial slice adder.
// Fixes the slice width that every slice netlist must implement.
package adder_slice_pkg;

    localparam int SLICE_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    function automatic int nslices(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/adder_slice_seq_if.sv
// Operand/result handshake bundle for adder_slice_seq.
// err exists only when ADDER_SLICE_SEQ_EXACT_CHECK_EN is defined.
interface adder_slice_seq_if #(
    parameter int WIDTH = 12
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;
`ifdef ADDER_SLICE_SEQ_EXACT_CHECK_EN
    logic             err;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy, err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy, err
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );
`endif

endinterface

// File: rtl/adder_slice3.sv
// Exact 3-bit ripple-carry slice adder, purely combinational.
// Approximate netlists replace this module with the same port list.
module adder_slice3
    import adder_slice_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    // Ripple the carry bit by bit through the slice
    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/adder_slice_seq.sv
// Digit-serial adder: one 3-bit slice per cycle, LSB first, carry registered.
// Optional macro ADDER_SLICE_SEQ_EXACT_CHECK_EN adds an exact-reference err flag.
module adder_slice_seq
    import adder_slice_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int SLICE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    adder_slice_seq_if.slave  bus
);

    localparam int NSL = nslices(WIDTH);
    localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSL - 1);

    if (SLICE != SLICE_W) begin : g_bad_slice
        $error("adder_slice_seq: SLICE must equal the slice adder width");
    end
    if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
        $error("adder_slice_seq: WIDTH must be a positive multiple of SLICE");
    end

    state_e state;
    state_e state_nxt;

    logic [NSL-1:0][SLICE_W-1:0] a_reg;
    logic [NSL-1:0][SLICE_W-1:0] b_reg;
    logic [NSL-1:0][SLICE_W-1:0] sum_reg;
    logic                        carry_reg;
    logic [IW-1:0]               idx;

    logic [SLICE_W-1:0] s_sum;
    logic               s_cout;
    logic               accept;
    logic               last;

    assign accept = (state == S_IDLE) && bus.in_valid;
    assign last   = (idx == LAST);

    adder_slice3 u_slice (
        .a    (a_reg[idx]),
        .b    (b_reg[idx]),
        .cin  (carry_reg),
        .sum  (s_sum),
        .cout (s_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: accept, walk all slices, hold result until taken
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.in_valid) state_nxt = S_RUN;
            S_RUN:   if (last) state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, write one slice per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else if (accept) begin
            a_reg     <= bus.in_a;
            b_reg     <= bus.in_b;
            sum_reg   <= '0;
            carry_reg <= bus.in_cin;
            idx       <= '0;
        end else if (state == S_RUN) begin
            sum_reg[idx] <= s_sum;
            carry_reg    <= s_cout;
            idx          <= last ? '0 : idx + 1'b1;
        end
    end

`ifdef ADDER_SLICE_SEQ_EXACT_CHECK_EN
    logic [WIDTH:0] ref_reg;

    // Exact reference sum captured alongside the operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_reg <= '0;
        end else if (accept) begin
            ref_reg <= {1'b0, bus.in_a} + {1'b0, bus.in_b}
                     + {{WIDTH{1'b0}}, bus.in_cin};
        end
    end
`endif

    // Outputs decoded from state; result visible only in DONE
    always_comb begin
        bus.in_ready  = (state == S_IDLE);
        bus.busy      = (state == S_RUN);
        bus.out_valid = (state == S_DONE);
        bus.out_sum   = (state == S_DONE) ? WIDTH'(sum_reg) : '0;
        bus.out_cout  = (state == S_DONE) ? carry_reg : 1'b0;
`ifdef ADDER_SLICE_SEQ_EXACT_CHECK_EN
        bus.err = (state == S_DONE) && ({carry_reg, WIDTH'(sum_reg)} != ref_reg);
`endif
    end

endmodule

// File: tb/tb_adder_slice_seq.sv
// Self-checking bench for adder_slice_seq (WIDTH=12).
// Checks err as well when ADDER_SLICE_SEQ_EXACT_CHECK_EN is defined.
module tb_adder_slice_seq;

    localparam int W = 12;

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_bad = 0;

    adder_slice_seq_if #(.WIDTH(W)) bus ();

    adder_slice_seq #(.WIDTH(W), .SLICE(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
        int unsigned t;
        t = int'(a) + int'(b) + int'(c);
        return (W + 1)'(t);
    endfunction

    // One directed operation; hold = cycles of out_ready low in DONE
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input int hold);
        logic [W:0] exp;
        logic [W-1:0] s0;
        logic c0;
        int lat;
        int bcnt;
        exp = model(a, b, c);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = c;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = '1;
        bus.in_b     = '1;
        lat  = 0;
        bcnt = 0;
        while (!bus.out_valid && lat < 30) begin
            if (bus.busy) bcnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd4);
        chk({tag, "_sum"}, 32'(bus.out_sum), 32'(exp[W-1:0]));
        chk({tag, "_cout"}, 32'(bus.out_cout), 32'(exp[W]));
`ifdef ADDER_SLICE_SEQ_EXACT_CHECK_EN
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
`endif
        s0 = bus.out_sum;
        c0 = bus.out_cout;
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = W'($urandom);
            bus.in_b     = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_sum"}, 32'(bus.out_sum), 32'(s0));
            chk({tag, "_hold_cout"}, 32'(bus.out_cout), 32'(c0));
            chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [W:0] q[$];
        logic [W:0] e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;
        int sent;
        int got;
        int cyc;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
        chk("rst_out_cout", 32'(bus.out_cout), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
`ifdef ADDER_SLICE_SEQ_EXACT_CHECK_EN
        chk("rst_err", 32'(bus.err), 32'd0);
`endif
        rst_n = 1'b1;

        do_op("basic", 12'h123, 12'h456, 1'b0, 0);
        chk("basic_const", 32'(model(12'h123, 12'h456, 1'b0)), 32'h579);
        do_op("ripple", 12'hFFF, 12'h001, 1'b0, 0);
        do_op("allones", 12'hFFF, 12'hFFF, 1'b1, 0);
        do_op("backpressure", 12'hABC, 12'h987, 1'b1, 5);

        // Reset during the second RUN cycle
        @(negedge clk);
        bus.in_a     = 12'h7FF;
        bus.in_b     = 12'h801;
        bus.in_cin   = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_sum", 32'(bus.out_sum), 32'd0);
        chk("mid_rst_out_cout", 32'(bus.out_cout), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_no_valid", 32'(bus.out_valid), 32'd0);
        end
        do_op("after_rst", 12'h00A, 12'h005, 1'b0, 0);

        // Random back-to-back run against a result queue
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 100 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = 1'($urandom);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_extra_result", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_sum", 32'(bus.out_sum), 32'(e[W-1:0]));
                    chk("rnd_cout", 32'(bus.out_cout), 32'(e[W]));
`ifdef ADDER_SLICE_SEQ_EXACT_CHECK_EN
                    chk("rnd_err", 32'(bus.err), 32'd0);
`endif
                end
                got++;
            end
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            bus.in_a     = ra;
            bus.in_b     = rb;
            bus.in_cin   = rc;
            bus.in_valid = (sent < 100) && ($urandom_range(3, 0) != 0);
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(ra, rb, rc));
                sent++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("rnd_sent", 32'(sent), 32'd100);
        chk("rnd_got", 32'(got), 32'd100);
        chk("rnd_left", 32'(q.size()), 32'd0);
        repeat (8) @(negedge clk);
        chk("rnd_tail_valid", 32'(bus.out_valid), 32'd0);
        chk("rnd_tail_ready", 32'(bus.in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
